// File: rtl/multicycle_control_if.sv
// Bundle between the multicycle controller and its datapath.
//   Op, MemReady      : datapath -> controller (opcode field, memory handshake)
//   PCWrite..RegDst   : controller -> datapath, single-bit datapath controls
//   PCSource          : PC mux select (00 ALU, 01 ALUOut, 10 jump target)
//   ALUSrcB           : ALU B select (00 RD2, 01 const 4, 10 SE, 11 SE<<2)
//   ALUop             : 00 add, 01 subtract, 10 decode funct
//   IllegalOp         : one-cycle pulse on an undefined opcode in DECODE
//   State             : current controller state, for debug
interface multicycle_control_if;
  logic [5:0] Op;
  logic       MemReady;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic       RegWrite;
  logic       RegDst;
  logic [1:0] PCSource;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUop;
  logic       IllegalOp;
  logic [3:0] State;

  // Controller side
  modport master (
    input  Op, MemReady,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA,
           RegWrite, RegDst, PCSource, ALUSrcB, ALUop, IllegalOp, State
  );

  // Datapath side
  modport slave (
    output Op, MemReady,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA,
           RegWrite, RegDst, PCSource, ALUSrcB, ALUop, IllegalOp, State
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style main controller (R-type, lw, sw, beq, j, optional addi).
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; returns the FSM to FETCH
//   bus   : multicycle_control_if.master -- Op/MemReady in, datapath controls and State out
// Parameter:
//   ADDI_EN : 1 decodes addi (001000); 0 treats it as an illegal opcode.
module multicycle_control #(
  parameter int unsigned ADDI_EN = 1
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  localparam logic [3:0] StFetch  = 4'd0;
  localparam logic [3:0] StDecode = 4'd1;
  localparam logic [3:0] StMemAdr = 4'd2;
  localparam logic [3:0] StMemRd  = 4'd3;
  localparam logic [3:0] StMemWb  = 4'd4;
  localparam logic [3:0] StMemWr  = 4'd5;
  localparam logic [3:0] StExec   = 4'd6;
  localparam logic [3:0] StAluWb  = 4'd7;
  localparam logic [3:0] StBranch = 4'd8;
  localparam logic [3:0] StJump   = 4'd9;
  localparam logic [3:0] StAddiEx = 4'd10;
  localparam logic [3:0] StAddiWb = 4'd11;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  localparam logic AddiOn = (ADDI_EN != 0);

  logic [3:0] state_q, state_d;
  logic [3:0] out_state;
  logic       op_legal;

  always_comb begin
    op_legal = 1'b0;
    case (bus.Op)
      OpRtype, OpLw, OpSw, OpBeq, OpJ: op_legal = 1'b1;
      OpAddi:                          op_legal = AddiOn;
      default:                         op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = bus.MemReady ? StDecode : StFetch;
      StDecode: begin
        case (bus.Op)
          OpRtype:     state_d = StExec;
          OpLw, OpSw:  state_d = StMemAdr;
          OpBeq:       state_d = StBranch;
          OpJ:         state_d = StJump;
          OpAddi:      state_d = AddiOn ? StAddiEx : StFetch;
          default:     state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (bus.Op == OpLw) ? StMemRd : StMemWr;
      StMemRd:  state_d = bus.MemReady ? StMemWb : StMemRd;
      StMemWb:  state_d = StFetch;
      StMemWr:  state_d = bus.MemReady ? StFetch : StMemWr;
      StExec:   state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
      StJump:   state_d = StFetch;
      StAddiEx: state_d = StAddiWb;
      StAddiWb: state_d = StFetch;
      default:  state_d = StFetch;  // unused codes 12-15 recover to FETCH
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.State = state_q;

  // While reset is held, decode as FETCH so the datapath sees fetch muxing immediately,
  // even when the register still holds a mid-wait state.
  assign out_state = reset ? StFetch : state_q;

  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.PCSource    = 2'b00;
    bus.ALUSrcB     = 2'b00;
    bus.ALUop       = 2'b00;
    bus.IllegalOp   = 1'b0;
    case (out_state)
      StFetch: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.MemReady;
        bus.PCWrite = bus.MemReady;
      end
      StDecode: begin
        bus.ALUSrcB   = 2'b11;
        bus.IllegalOp = ~op_legal;
      end
      StMemAdr: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      StMemRd: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      StMemWb: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
      end
      StMemWr: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      StExec: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUop   = 2'b10;
      end
      StAluWb: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
      end
      StBranch: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUop       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
      end
      StJump: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
      end
      StAddiEx: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      StAddiWb: begin
        bus.RegWrite = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      bus.PCWrite     = 1'b0;
      bus.PCWriteCond = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.IllegalOp   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: per-instruction expected state/control traces are built from the
// instruction class and a random MemReady wait plan, then compared cycle by cycle.
module tb_multicycle_control;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  multicycle_control_if bus ();
  multicycle_control_if bus0 ();

  assign bus0.Op       = bus.Op;
  assign bus0.MemReady = bus.MemReady;

  multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));
  multicycle_control #(.ADDI_EN(0)) dut_noaddi (.clk(clk), .reset(reset), .bus(bus0));

  always #5 clk = ~clk;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpAddi = 6'b001000;

  typedef struct {
    logic [3:0] st;
    logic       mr;
  } step_t;

  step_t trace[$];

  function automatic bit legal(input logic [5:0] op, input bit addi_en);
    return (op == OpR) || (op == OpLw) || (op == OpSw) || (op == OpBeq) || (op == OpJ) ||
           ((op == OpAddi) && addi_en);
  endfunction

  // Control table per state; rst gives the values required while reset is held.
  function automatic logic [16:0] exp_ctrl(input int st, input logic mr, input bit ill,
                                           input bit rst);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd, io;
    logic [1:0] pcs, asb, aop;
    int s;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd, io} = '0;
    pcs = 2'b00; asb = 2'b00; aop = 2'b00;
    s = rst ? 0 : st;
    case (s)
      0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      1:  begin asb = 2'b11; io = ill; end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: begin rw = 1; end
      default: ;
    endcase
    if (rst) begin pcw = 0; pcwc = 0; mwr = 0; irw = 0; rw = 0; io = 0; end
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd, pcs, asb, aop, io};
  endfunction

  function automatic logic [16:0] act_ctrl();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
            bus.MemtoReg, bus.ALUSrcA, bus.RegWrite, bus.RegDst, bus.PCSource, bus.ALUSrcB,
            bus.ALUop, bus.IllegalOp};
  endfunction

  task automatic push_any(input logic [3:0] st);
    trace.push_back('{st: st, mr: 1'($urandom)});
  endtask

  // A memory-wait phase: n cycles with MemReady low, then one with it high.
  task automatic push_wait(input logic [3:0] st, input int n);
    for (int i = 0; i < n; i++) trace.push_back('{st: st, mr: 1'b0});
    trace.push_back('{st: st, mr: 1'b1});
  endtask

  task automatic build(input logic [5:0] op, input int wf, input int wm);
    trace.delete();
    push_wait(4'd0, wf);
    push_any(4'd1);
    if (legal(op, 1'b1)) begin
      case (op)
        OpR:    begin push_any(4'd6); push_any(4'd7); end
        OpLw:   begin push_any(4'd2); push_wait(4'd3, wm); push_any(4'd4); end
        OpSw:   begin push_any(4'd2); push_wait(4'd5, wm); end
        OpBeq:  push_any(4'd8);
        OpJ:    push_any(4'd9);
        OpAddi: begin push_any(4'd10); push_any(4'd11); end
        default: ;
      endcase
    end
  endtask

  // Op carries the instruction only where the FSM may look at it; elsewhere it is noise.
  task automatic run_trace(input logic [5:0] op, input string name, input int skip);
    logic [16:0] exp;
    for (int i = 0; i < trace.size() - skip; i++) begin
      @(negedge clk);
      bus.MemReady = trace[i].mr;
      bus.Op = (trace[i].st == 4'd1 || trace[i].st == 4'd2) ? op : 6'($urandom);
      #1;
      exp = exp_ctrl(int'(trace[i].st), trace[i].mr,
                     (trace[i].st == 4'd1) && !legal(op, 1'b1), 1'b0);
      tests++;
      if (bus.State !== trace[i].st) begin
        fails++;
        $display("FAIL %s step %0d state: got %0d expected %0d", name, i, bus.State,
                 trace[i].st);
      end
      tests++;
      if (act_ctrl() !== exp) begin
        fails++;
        $display("FAIL %s step %0d controls: got %b expected %b", name, i, act_ctrl(), exp);
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; bus.MemReady = 1'b1; bus.Op = 6'($urandom);
    @(negedge clk);
    reset = 1'b0; bus.MemReady = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; bus.MemReady = 1'b1; bus.Op = 6'($urandom);
    @(negedge clk);
    #1;
    tests++;
    if (bus.State !== 4'd0) begin
      fails++; $display("FAIL reset state: got %0d expected 0", bus.State);
    end
    tests++;
    if (bus0.State !== 4'd0) begin
      fails++; $display("FAIL reset state noaddi: got %0d expected 0", bus0.State);
    end
    tests++;
    if (act_ctrl() !== exp_ctrl(0, 1'b1, 1'b0, 1'b1)) begin
      fails++;
      $display("FAIL reset controls: got %b expected %b", act_ctrl(),
               exp_ctrl(0, 1'b1, 1'b0, 1'b1));
    end
    reset = 1'b0; bus.MemReady = 1'b0;
  endtask

  task automatic test_rtype();
    build(OpR, 0, 0); run_trace(OpR, "rtype", 0);
  endtask

  task automatic test_lw_wait();
    build(OpLw, 0, 2); run_trace(OpLw, "lw_wait", 0);
  endtask

  task automatic test_sw_beq();
    build(OpSw, 0, 0); run_trace(OpSw, "sw", 0);
    build(OpBeq, 0, 0); run_trace(OpBeq, "beq", 0);
  endtask

  task automatic test_illegal();
    build(6'b111111, 0, 0); run_trace(6'b111111, "illegal", 0);
    build(OpJ, 3, 0); run_trace(OpJ, "jump_fetch_wait", 0);
  endtask

  task automatic test_addi_disabled();
    logic [3:0] exp_main [4];
    logic [3:0] exp_off  [4];
    exp_main = '{4'd0, 4'd1, 4'd10, 4'd11};
    exp_off  = '{4'd0, 4'd1, 4'd0, 4'd1};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.MemReady = 1'b1; bus.Op = OpAddi;
      #1;
      tests++;
      if (bus.State !== exp_main[i]) begin
        fails++; $display("FAIL addi_on step %0d state: got %0d expected %0d", i, bus.State,
                          exp_main[i]);
      end
      tests++;
      if (bus0.State !== exp_off[i]) begin
        fails++; $display("FAIL addi_off step %0d state: got %0d expected %0d", i, bus0.State,
                          exp_off[i]);
      end
      tests++;
      if (bus0.IllegalOp !== 1'(i % 2)) begin
        fails++; $display("FAIL addi_off step %0d illegal: got %b expected %b", i,
                          bus0.IllegalOp, 1'(i % 2));
      end
    end
  endtask

  task automatic test_reset_midwait();
    build(OpSw, 0, 3);
    run_trace(OpSw, "sw_pre_reset", 2);
    @(negedge clk);
    reset = 1'b1; bus.MemReady = 1'b0;
    #1;
    tests++;
    if (bus.MemWrite !== 1'b0) begin
      fails++; $display("FAIL midwait memwrite: got %b expected 0", bus.MemWrite);
    end
    tests++;
    if (bus.State !== 4'd5) begin
      fails++; $display("FAIL midwait state before edge: got %0d expected 5", bus.State);
    end
    tests++;
    if (act_ctrl() !== exp_ctrl(0, 1'b0, 1'b0, 1'b1)) begin
      fails++; $display("FAIL midwait controls: got %b expected %b", act_ctrl(),
                        exp_ctrl(0, 1'b0, 1'b0, 1'b1));
    end
    @(negedge clk);
    #1;
    tests++;
    if (bus.State !== 4'd0) begin
      fails++; $display("FAIL midwait state after edge: got %0d expected 0", bus.State);
    end
    reset = 1'b0; bus.MemReady = 1'b0;
    build(OpLw, 1, 1); run_trace(OpLw, "lw_after_reset", 0);
  endtask

  task automatic test_random();
    logic [5:0] ops [7];
    logic [5:0] op;
    ops = '{OpR, OpLw, OpSw, OpBeq, OpJ, OpAddi, 6'b000000};
    for (int n = 0; n < 40; n++) begin
      ops[6] = 6'($urandom);
      op = ops[$urandom_range(0, 6)];
      build(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      run_trace(op, "random", 0);
    end
  endtask

  initial begin
    bus.Op = 6'd0;
    bus.MemReady = 1'b0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_beq();
    test_illegal();
    test_addi_disabled();
    test_reset_midwait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
